spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Shares one 8-bit SPI master among `N_REQ` requesters using round-robin arbitration. It latches the winning requester's byte and pulses the master's `tx_enable` for one cycle. It tracks the frame by watching the master's `cs`, waits out the master's stop phase, and then returns a one-cycle `ack` to the requester. The block sits between the client logic and `spi_master`, and is the only driver of the master's `tx_enable` and `din`.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `STOP_CYCLES`, default 8: clk cycles the master keeps `cs` high in its stop phase before it returns to idle.
- `LAUNCH_TIMEOUT`, default 4: cycles after `tx_enable` within which `cs` must fall.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N_REQ  per-requester level request; held high until the matching `ack` or `err`.
- `req_data`  in  8*N_REQ  byte for requester i in bits [8i+7:8i]; sampled only at grant.
- `ack`  out  N_REQ  one-cycle pulse on the granted bit when its frame has fully completed.
- `err`  out  1  one-cycle pulse when a launch times out.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(N_REQ)  index of the current or last granted requester.
- `tx_enable`  out  1  to the master; registered.
- `din`  out  8  to the master; holds the latched byte, stable for the entire frame.
- `cs_in`  in  1  the master's `cs` (active-low).

## Operation
- States:
  - **IDLE**: if any `req` bit is high, grant via round-robin, latch `din <= req_data[grant]`, set `tx_enable <= 1`, and go to LAUNCH.
  - **LAUNCH**: `tx_enable <= 0`, so it is high for exactly one cycle. If `cs_in == 0`, go to ACTIVE. Otherwise increment the timeout counter; when it reaches `LAUNCH_TIMEOUT`, pulse `err`, do not ack, and go to IDLE.
  - **ACTIVE**: wait for `cs_in == 1`, then load the drain counter and go to DRAIN.
  - **DRAIN**: count `STOP_CYCLES-1` down to 0; at 0, pulse `ack[grant_id]` and go to IDLE.
- Round-robin: the search starts at `(last_grant+1) mod N_REQ` and wraps around. The pointer advances on every grant, including grants that end in `err`.
- `req` changes after grant are ignored until IDLE. A `req` bit dropped before grant is never served.
- `req_data` changes after grant do not affect `din`.
- `din` changes only at a grant; it holds its value in IDLE.
- `tx_enable` is never high outside the single cycle after a grant. This prevents the master from auto-restarting out of idle.

## Timing
- Reset values:
  - state IDLE, `busy=0`, `tx_enable=0`, `din=8'h00`, `ack=0`, `err=0`, `grant_id=0`.
  - RR pointer set so that requester 0 has highest priority first.
- `rst` mid-frame aborts with no `ack`. The master must share the same `rst` so that both return to idle together.
- Grant decided at cycle k (IDLE, `req` seen):
  - `tx_enable` is high at k+1.
  - The master's `cs` falls at k+2, so LAUNCH lasts 1–2 cycles.
- Frame length on `cs`:
  - 8 start cycles plus 64 transmit cycles: `cs` is low for k+2..k+73 and rises at m = k+74.
  - `ack` pulses at m+`STOP_CYCLES` = k+82.
  - IDLE resumes at k+83, and the next `tx_enable` is no earlier than k+84. The master is idle from m+8 onward, so this is safe.
- Back-to-back: with `req` held continuously, consecutive `tx_enable` pulses are 83 cycles apart.
- Simultaneous requests: exactly one grant per IDLE cycle. No grant can occur in the same cycle as an `ack`, because `ack` is issued in DRAIN.
- A `cs_in` glitch high in LAUNCH is ignored. Only a 0 is acted on.

## Structure
- Shared package `spi_pkg`:
  - `arb_state_t` enum {IDLE, LAUNCH, ACTIVE, DRAIN}.
  - `SPI_FRAME_BITS=8`.
  - `SPI_PHASE_CYCLES=8`.
- Sub-module `rr_arbiter`: purely combinational. Takes `req`, pointer, `valid`, and `grant_id` one-hot/index. The FSM owns the pointer register.
- Top level: FSM, timeout/drain counter (`$clog2` of the max of the two parameters, plus 1), data register, and output registers.

## Test plan
- Single `req[2]=1` with `8'hA5` at k → `tx_enable` is high at k+1 only, `din=8'hA5` through the frame, `ack[2]` at k+82, `busy` falls at k+83, and the master's MOSI shows 1010_0101 MSB first.
- `req=4'b1111` held → grants follow 0,1,2,3,0 with consecutive `tx_enable` pulses 83 cycles apart; each `ack` matches its `grant_id`.
- `req[1]` high and `req_data` changed to `8'h3C` mid-frame → `din` keeps its grant value; the next grant to 1 latches `8'h3C`.
- `cs_in` tied high → `err` pulses 4 cycles after LAUNCH entry, no `ack` is issued, and the next requester is granted.
- `rst` pulsed at cycle 40 of a frame → all outputs return to reset values the next cycle, no `ack` is issued, and a fresh `req[0]` is granted to requester 0.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI arbitration slice.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    localparam int SPI_FRAME_BITS   = 8;
    localparam int SPI_PHASE_CYCLES = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick; search starts after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] grant_id,
    output logic [N_REQ-1:0] grant_oh
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        valid    = 1'b0;
        grant_id = '0;
        grant_oh = '0;
        w_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!valid && req[w_idx]) begin
                valid           = 1'b1;
                grant_id        = w_idx;
                grant_oh[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_arbiter
// Description : Round-robin sharing of one SPI master; launch, track, ack.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int STOP_CYCLES    = 8,
    parameter int LAUNCH_TIMEOUT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req,
    input  logic [SPI_FRAME_BITS*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]                ack,
    output logic                            err,
    output logic                            busy,
    output logic [$clog2(N_REQ)-1:0]        grant_id,
    output logic                            tx_enable,
    output logic [SPI_FRAME_BITS-1:0]       din,
    input  logic                            cs_in
);

    localparam int c_IDX_W = $clog2(N_REQ);
    localparam int c_CNT_W = $clog2(max_int(STOP_CYCLES, LAUNCH_TIMEOUT)) + 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LAUNCH_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LOAD   = c_CNT_W'(STOP_CYCLES - 1);

    arb_state_t                r_state;
    logic [c_IDX_W-1:0]        r_ptr;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [N_REQ-1:0]          r_grant_oh;
    logic [N_REQ-1:0]          r_ack;
    logic                      r_err;
    logic                      r_busy;
    logic [c_IDX_W-1:0]        r_grant_id;
    logic                      r_tx_enable;
    logic [SPI_FRAME_BITS-1:0] r_din;

    logic                      w_valid;
    logic [c_IDX_W-1:0]        w_grant_id;
    logic [N_REQ-1:0]          w_grant_oh;
    logic [SPI_FRAME_BITS-1:0] w_bytes [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
        assign w_bytes[gi] = req_data[gi*SPI_FRAME_BITS +: SPI_FRAME_BITS];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr (
        .req      (req),
        .ptr      (r_ptr),
        .valid    (w_valid),
        .grant_id (w_grant_id),
        .grant_oh (w_grant_oh)
    );

    // ack is raised one cycle early so it lands on the last DRAIN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= c_IDX_W'(N_REQ - 1);
            r_cnt       <= '0;
            r_grant_oh  <= '0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_grant_id  <= '0;
            r_tx_enable <= 1'b0;
            r_din       <= '0;
        end else begin
            r_tx_enable <= 1'b0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant_id  <= w_grant_id;
                        r_grant_oh  <= w_grant_oh;
                        r_ptr       <= w_grant_id;
                        r_din       <= w_bytes[w_grant_id];
                        r_tx_enable <= 1'b1;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!cs_in) begin
                        r_state <= ACTIVE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_in) begin
                        r_cnt   <= c_DRAIN_LOAD;
                        r_state <= DRAIN;
                        if (STOP_CYCLES == 1) begin
                            r_ack <= r_grant_oh;
                        end
                    end
                end
                DRAIN: begin
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == c_CNT_W'(1)) begin
                            r_ack <= r_grant_oh;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign busy      = r_busy;
    assign grant_id  = r_grant_id;
    assign tx_enable = r_tx_enable;
    assign din       = r_din;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_arbiter
// Description : Scoreboard bench for spi_arbiter with a behavioural SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        err;
    logic        busy;
    logic [1:0]  grant_id;
    logic        tx_enable;
    logic [7:0]  din;
    logic        cs;
    logic        mosi;
    bit          cs_stuck;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   m_ptr;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .grant_id  (grant_id),
        .tx_enable (tx_enable),
        .din       (din),
        .cs_in     (cs)
    );

    // Master model: 8 start + 64 transmit cycles with cs low, 8 stop cycles.
    int         m_cnt;
    logic [1:0] m_st;
    logic [7:0] m_byte;
    always @(posedge clk) begin
        if (rst) begin
            cs <= 1'b1; m_st <= 2'd0; m_cnt <= 0; m_byte <= 8'h00;
        end else begin
            case (m_st)
                2'd0: if (tx_enable && !cs_stuck) begin
                    cs <= 1'b0; m_st <= 2'd1; m_cnt <= 0; m_byte <= din;
                end
                2'd1: if (m_cnt == 71) begin
                    cs <= 1'b1; m_st <= 2'd2; m_cnt <= 0;
                end else m_cnt <= m_cnt + 1;
                default: if (m_cnt == 7) m_st <= 2'd0; else m_cnt <= m_cnt + 1;
            endcase
        end
    end

    always_comb begin
        int bi;
        bi   = 7 - (m_cnt - 8) / 8;
        mosi = 1'b0;
        if (m_st == 2'd1 && m_cnt >= 8) mosi = m_byte[bi[2:0]];
    end

    function automatic int rr_next(input logic [3:0] r, input int p);
        for (int i = 1; i <= 4; i++) begin
            int idx;
            idx = (p + i) % 4;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic push_grant(input logic [3:0] r);
        exp_t e;
        int   g;
        g      = rr_next(r, m_ptr);
        m_ptr  = g;
        e.id   = g[1:0];
        e.data = req_data[8*g +: 8];
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: grant seen with no expectation queued");
            e = '0;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic wait_tx(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (tx_enable) ok = 1'b1;
        end
    endtask

    task automatic wait_ack(input int budget, output bit ok, output logic [3:0] v);
        ok = 1'b0; v = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin ok = 1'b1; v = ack; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; req_data = '0; cs_stuck = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_ptr = 3;
        sb.delete();
        checks += 6;
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (tx_enable !== 1'b0) begin errors++; $display("FAIL reset_tx got %b want 0", tx_enable); end
        if (din !== 8'h00)      begin errors++; $display("FAIL reset_din got %h want 00", din); end
        if (ack !== 4'b0)       begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
        if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", err); end
        if (grant_id !== 2'd0)  begin errors++; $display("FAIL reset_gid got %0d want 0", grant_id); end
    endtask

    task automatic test_single;
        exp_t       e;
        int         k, rel, tx_rel, tx_cnt, ack_rel, busy_fall, bi;
        bit         din_bad;
        logic [3:0] ack_v;
        logic [7:0] mosi_b;
        req_data = $urandom;
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        push_grant(req);
        k = cyc; tx_rel = -1; tx_cnt = 0; ack_rel = -1; busy_fall = -1;
        din_bad = 1'b0; ack_v = '0; mosi_b = '0; e = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rel = cyc - k;
            if (tx_enable) begin
                tx_cnt++;
                if (tx_rel < 0) begin
                    tx_rel = rel;
                    pop_exp(e);
                    checks += 2;
                    if (grant_id !== e.id) begin errors++; $display("FAIL single_gid got %0d want %0d", grant_id, e.id); end
                    if (din !== e.data)    begin errors++; $display("FAIL single_din got %h want %h", din, e.data); end
                end
            end
            if (rel >= 1 && rel <= 82 && din !== 8'hA5) din_bad = 1'b1;
            if (rel >= 14 && rel <= 70 && (rel - 14) % 8 == 0) begin
                bi = 7 - (rel - 14) / 8;
                mosi_b[bi[2:0]] = mosi;
            end
            if (ack !== 4'b0 && ack_rel < 0) begin ack_rel = rel; ack_v = ack; req = '0; end
            if (rel >= 2 && !busy && busy_fall < 0) busy_fall = rel;
        end
        checks += 7;
        if (tx_rel != 1)       begin errors++; $display("FAIL single_tx_time got %0d want 1", tx_rel); end
        if (tx_cnt != 1)       begin errors++; $display("FAIL single_tx_count got %0d want 1", tx_cnt); end
        if (din_bad)           begin errors++; $display("FAIL single_din_stable got unstable want A5"); end
        if (mosi_b !== 8'hA5)  begin errors++; $display("FAIL single_mosi got %h want a5", mosi_b); end
        if (ack_v !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", ack_v); end
        if (ack_rel != 82)     begin errors++; $display("FAIL single_ack_time got %0d want 82", ack_rel); end
        if (busy_fall != 83)   begin errors++; $display("FAIL single_busy_fall got %0d want 83", busy_fall); end
    endtask

    task automatic test_back_to_back;
        exp_t       e;
        bit         ok;
        logic [3:0] v;
        int         prev_tx;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 3;
        req_data = 32'h13121110;
        req = 4'hF;
        for (int n = 0; n < 5; n++) push_grant(req);
        prev_tx = -1;
        for (int n = 0; n < 5; n++) begin
            wait_tx(200, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b_tx_timeout got none want grant %0d", n); break; end
            if (n > 0) begin
                checks++;
                if (cyc - prev_tx != 83) begin errors++; $display("FAIL b2b_spacing got %0d want 83", cyc - prev_tx); end
            end
            prev_tx = cyc;
            pop_exp(e);
            checks += 2;
            if (grant_id !== e.id) begin errors++; $display("FAIL b2b_gid got %0d want %0d", grant_id, e.id); end
            if (din !== e.data)    begin errors++; $display("FAIL b2b_din got %h want %h", din, e.data); end
            wait_ack(200, ok, v);
            if (n == 4) req = '0;
            checks++;
            if (v !== (4'b0001 << e.id)) begin errors++; $display("FAIL b2b_ack got %b want id %0d", v, e.id); end
        end
    endtask

    task automatic test_data_change;
        exp_t       e;
        bit         ok;
        logic [3:0] v;
        repeat (3) @(negedge clk);
        req_data[15:8] = 8'h77;
        req = 4'b0010;
        push_grant(req);
        wait_tx(20, ok);
        pop_exp(e);
        checks += 3;
        if (!ok)               begin errors++; $display("FAIL chg_tx_timeout got none want grant"); end
        if (grant_id !== e.id) begin errors++; $display("FAIL chg_gid got %0d want %0d", grant_id, e.id); end
        if (din !== 8'h77)     begin errors++; $display("FAIL chg_din got %h want 77", din); end
        repeat (40) @(negedge clk);
        req_data[15:8] = 8'h3C;
        push_grant(req);
        repeat (5) @(negedge clk);
        checks++;
        if (din !== 8'h77) begin errors++; $display("FAIL chg_din_hold got %h want 77", din); end
        wait_ack(100, ok, v);
        checks += 2;
        if (v !== 4'b0010) begin errors++; $display("FAIL chg_ack got %b want 0010", v); end
        if (din !== 8'h77) begin errors++; $display("FAIL chg_din_at_ack got %h want 77", din); end
        wait_tx(20, ok);
        pop_exp(e);
        checks += 3;
        if (!ok)               begin errors++; $display("FAIL chg_tx2_timeout got none want grant"); end
        if (grant_id !== e.id) begin errors++; $display("FAIL chg_gid2 got %0d want %0d", grant_id, e.id); end
        if (din !== 8'h3C)     begin errors++; $display("FAIL chg_din2 got %h want 3c", din); end
        wait_ack(100, ok, v);
        req = '0;
        checks++;
        if (v !== 4'b0010) begin errors++; $display("FAIL chg_ack2 got %b want 0010", v); end
    endtask

    task automatic test_timeout;
        exp_t e;
        bit   ok, ack_seen, busy_at_err;
        int   t, err_rel;
        repeat (3) @(negedge clk);
        cs_stuck = 1'b1;
        req_data[7:0] = 8'h01; req_data[15:8] = 8'h02;
        req = 4'b0011;
        push_grant(req);
        push_grant(req & ~(4'b0001 << m_ptr));
        for (int n = 0; n < 2; n++) begin
            wait_tx(20, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL to_tx_timeout got none want grant %0d", n); break; end
            t = cyc;
            pop_exp(e);
            checks++;
            if (grant_id !== e.id) begin errors++; $display("FAIL to_gid got %0d want %0d", grant_id, e.id); end
            err_rel = -1; ack_seen = 1'b0; busy_at_err = 1'b1;
            for (int i = 0; i < 20 && err_rel < 0; i++) begin
                @(negedge clk);
                if (ack !== 4'b0) ack_seen = 1'b1;
                if (err) begin err_rel = cyc - t; busy_at_err = busy; req[e.id] = 1'b0; end
            end
            checks += 3;
            if (err_rel != 4)  begin errors++; $display("FAIL to_err_time got %0d want 4", err_rel); end
            if (ack_seen)      begin errors++; $display("FAIL to_no_ack got ack want none"); end
            if (busy_at_err)   begin errors++; $display("FAIL to_busy got 1 want 0"); end
        end
        wait_tx(30, ok);
        checks++;
        if (ok) begin errors++; $display("FAIL to_spurious_grant got grant want none"); end
        cs_stuck = 1'b0;
    endtask

    task automatic test_reset_mid;
        exp_t       e;
        bit         ok;
        logic [3:0] v;
        req_data[23:16] = 8'h5A; req_data[7:0] = 8'hC3;
        req = 4'b0100;
        push_grant(req);
        wait_tx(20, ok);
        pop_exp(e);
        checks += 2;
        if (!ok)               begin errors++; $display("FAIL rm_tx_timeout got none want grant"); end
        if (grant_id !== e.id) begin errors++; $display("FAIL rm_gid got %0d want %0d", grant_id, e.id); end
        repeat (38) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (busy !== 1'b0)      begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
        if (din !== 8'h00)      begin errors++; $display("FAIL rm_din got %h want 00", din); end
        if (grant_id !== 2'd0)  begin errors++; $display("FAIL rm_gid_reset got %0d want 0", grant_id); end
        if (ack !== 4'b0)       begin errors++; $display("FAIL rm_ack got %b want 0000", ack); end
        if (tx_enable !== 1'b0) begin errors++; $display("FAIL rm_tx got %b want 0", tx_enable); end
        rst = 1'b0;
        req = 4'b0001;
        m_ptr = 3;
        sb.delete();
        push_grant(req);
        wait_tx(20, ok);
        pop_exp(e);
        checks += 3;
        if (!ok)               begin errors++; $display("FAIL rm_tx2_timeout got none want grant"); end
        if (grant_id !== e.id) begin errors++; $display("FAIL rm_gid2 got %0d want %0d", grant_id, e.id); end
        if (din !== e.data)    begin errors++; $display("FAIL rm_din2 got %h want %h", din, e.data); end
        wait_ack(120, ok, v);
        req = '0;
        checks++;
        if (v !== 4'b0001) begin errors++; $display("FAIL rm_ack2 got %b want 0001", v); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_data_change();
        test_timeout();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
